// File: rtl/fetch_decode_ctrl.sv
// fetch_decode_ctrl: IF/ID hazard and sequencing controller.
// Each cycle it decides whether PC and IF/ID advance, hold or flush, and
// whether ID/EX receives a bubble. It covers load-use stalls (multi-cycle),
// instruction-memory wait states and taken-branch redirects from EX.
// Optional build macro HAZARD_PERF_CNT_EN adds saturating event counters.
//
// state     | meaning
// ----------+---------------------------------------------------------
// INIT      | first cycle out of reset, pipeline front end held at NOP
// RUN       | normal issue, hazards evaluated every cycle
// LU_STALL  | remaining cycles of a load-use stall, counter running
// IMEM_WAIT | fetch outstanding, ID drains while IF/ID holds NOP
module fetch_decode_ctrl #(
    parameter int          LOAD_LAT  = 1,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [4:0]  id_rs1_i,
    input  logic [4:0]  id_rs2_i,
    input  logic        id_use_rs1_i,
    input  logic        id_use_rs2_i,
    input  logic        ex_memread_i,
    input  logic [4:0]  ex_rd_i,
    input  logic        ex_branch_taken_i,
    input  logic        imem_ready_i,
    output logic        pc_we_o,
    output logic        pc_sel_o,
    output logic        fd_we_o,
    output logic        fd_flush_o,
    output logic        de_bubble_o,
    output logic        imem_abort_o,
`ifdef HAZARD_PERF_CNT_EN
    output logic [31:0] stall_cnt_o,
    output logic [31:0] flush_cnt_o,
    output logic [31:0] wait_cnt_o,
`endif
    output logic [1:0]  state_o
);

    // Reject parameter values the stall counter or the IF/ID flush path cannot honour.
    if (LOAD_LAT < 1 || LOAD_LAT > 7) begin : g_bad_load_lat
        $error("fetch_decode_ctrl: LOAD_LAT must be within 1..7");
    end
    if (NOP_INSTR[1:0] != 2'b11) begin : g_bad_nop
        $error("fetch_decode_ctrl: NOP_INSTR is not a 32-bit encoding");
    end

    typedef enum logic [1:0] {
        S_INIT      = 2'd0,
        S_RUN       = 2'd1,
        S_LU_STALL  = 2'd2,
        S_IMEM_WAIT = 2'd3
    } state_e;

    localparam logic [2:0] LU_RELOAD = 3'(LOAD_LAT - 1);

    state_e     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       lu_hz;
    logic       br;

    assign br    = ex_branch_taken_i;
    assign lu_hz = ex_memread_i && (ex_rd_i != 5'd0) &&
                   ((id_use_rs1_i && (id_rs1_i == ex_rd_i)) ||
                    (id_use_rs2_i && (id_rs2_i == ex_rd_i)));

    // Next state, stall counter and output decode (branch > load-use > imem wait).
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pc_we_o      = 1'b0;
        pc_sel_o     = 1'b0;
        fd_we_o      = 1'b0;
        fd_flush_o   = 1'b0;
        de_bubble_o  = 1'b0;
        imem_abort_o = 1'b0;
        case (state_q)
            S_INIT: begin
                fd_we_o     = 1'b1;
                fd_flush_o  = 1'b1;
                de_bubble_o = 1'b1;
                state_d     = S_RUN;
            end
            S_RUN: begin
                if (br) begin
                    pc_we_o     = 1'b1;
                    pc_sel_o    = 1'b1;
                    fd_we_o     = 1'b1;
                    fd_flush_o  = 1'b1;
                    de_bubble_o = 1'b1;
                end else if (lu_hz) begin
                    de_bubble_o = 1'b1;
                    if (LOAD_LAT > 1) begin
                        state_d = S_LU_STALL;
                        cnt_d   = LU_RELOAD;
                    end
                end else if (!imem_ready_i) begin
                    fd_we_o    = 1'b1;
                    fd_flush_o = 1'b1;
                    state_d    = S_IMEM_WAIT;
                end else begin
                    pc_we_o = 1'b1;
                    fd_we_o = 1'b1;
                end
            end
            S_LU_STALL: begin
                if (br) begin
                    pc_we_o     = 1'b1;
                    pc_sel_o    = 1'b1;
                    fd_we_o     = 1'b1;
                    fd_flush_o  = 1'b1;
                    de_bubble_o = 1'b1;
                    cnt_d       = 3'd0;
                    state_d     = S_RUN;
                end else begin
                    de_bubble_o = 1'b1;
                    cnt_d       = cnt_q - 3'd1;
                    if (cnt_q == 3'd1) begin
                        state_d = S_RUN;
                    end
                end
            end
            S_IMEM_WAIT: begin
                if (br) begin
                    pc_we_o      = 1'b1;
                    pc_sel_o     = 1'b1;
                    fd_we_o      = 1'b1;
                    fd_flush_o   = 1'b1;
                    de_bubble_o  = 1'b1;
                    imem_abort_o = 1'b1;
                    state_d      = S_RUN;
                end else if (imem_ready_i) begin
                    pc_we_o = 1'b1;
                    fd_we_o = 1'b1;
                    state_d = S_RUN;
                end else begin
                    fd_we_o    = 1'b1;
                    fd_flush_o = 1'b1;
                end
            end
            default: begin
                state_d = S_INIT;
                cnt_d   = 3'd0;
            end
        endcase
    end

    // State and stall counter registers.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q <= S_INIT;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign state_o = state_q;

`ifdef HAZARD_PERF_CNT_EN
    logic        stall_ev, flush_ev, wait_ev;
    logic [31:0] stall_cnt_q, flush_cnt_q, wait_cnt_q;

    assign stall_ev = !br && ((state_q == S_LU_STALL) || ((state_q == S_RUN) && lu_hz));
    assign flush_ev = br && (state_q != S_INIT);
    assign wait_ev  = (state_q == S_IMEM_WAIT);

    // Saturating event counters; they hold at all-ones instead of wrapping.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
            wait_cnt_q  <= 32'd0;
        end else begin
            if (stall_ev && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_q <= stall_cnt_q + 32'd1;
            if (flush_ev && (flush_cnt_q != 32'hFFFF_FFFF)) flush_cnt_q <= flush_cnt_q + 32'd1;
            if (wait_ev  && (wait_cnt_q  != 32'hFFFF_FFFF)) wait_cnt_q  <= wait_cnt_q  + 32'd1;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
    assign wait_cnt_o  = wait_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_decode_ctrl.sv
// Directed bench for fetch_decode_ctrl. Main instance uses LOAD_LAT=3; a second
// instance with LOAD_LAT=1 shares all inputs to cover the single-cycle stall case.
module tb_fetch_decode_ctrl;

    logic       clk_i = 1'b0;
    logic       reset_i;
    logic [4:0] id_rs1_i, id_rs2_i, ex_rd_i;
    logic       id_use_rs1_i, id_use_rs2_i, ex_memread_i, ex_branch_taken_i, imem_ready_i;

    logic       pc_we_o, pc_sel_o, fd_we_o, fd_flush_o, de_bubble_o, imem_abort_o;
    logic [1:0] state_o;
    logic       pc_we1, pc_sel1, fd_we1, fd_flush1, de_bubble1, imem_abort1;
    logic [1:0] state1;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt_o, flush_cnt_o, wait_cnt_o;
    logic [31:0] stall_cnt1, flush_cnt1, wait_cnt1;
`endif

    int total = 0;
    int bad   = 0;

    // Output pattern {pc_we, pc_sel, fd_we, fd_flush, de_bubble, imem_abort}
    localparam logic [5:0] O_INIT  = 6'b001110;
    localparam logic [5:0] O_NORM  = 6'b101000;
    localparam logic [5:0] O_BR    = 6'b111110;
    localparam logic [5:0] O_STALL = 6'b000010;
    localparam logic [5:0] O_WAIT  = 6'b001100;
    localparam logic [5:0] O_ABORT = 6'b111111;
    localparam logic [1:0] ST_INIT = 2'd0, ST_RUN = 2'd1, ST_LU = 2'd2, ST_WAIT = 2'd3;

    wire [7:0] obs  = {state_o, pc_we_o, pc_sel_o, fd_we_o, fd_flush_o, de_bubble_o, imem_abort_o};
    wire [7:0] obs1 = {state1, pc_we1, pc_sel1, fd_we1, fd_flush1, de_bubble1, imem_abort1};

    always #5 clk_i = ~clk_i;

    fetch_decode_ctrl #(.LOAD_LAT(3)) u_dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
        .id_use_rs1_i(id_use_rs1_i), .id_use_rs2_i(id_use_rs2_i),
        .ex_memread_i(ex_memread_i), .ex_rd_i(ex_rd_i),
        .ex_branch_taken_i(ex_branch_taken_i), .imem_ready_i(imem_ready_i),
        .pc_we_o(pc_we_o), .pc_sel_o(pc_sel_o), .fd_we_o(fd_we_o),
        .fd_flush_o(fd_flush_o), .de_bubble_o(de_bubble_o), .imem_abort_o(imem_abort_o),
`ifdef HAZARD_PERF_CNT_EN
        .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o), .wait_cnt_o(wait_cnt_o),
`endif
        .state_o(state_o)
    );

    fetch_decode_ctrl #(.LOAD_LAT(1)) u_dut1 (
        .clk_i(clk_i), .reset_i(reset_i),
        .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
        .id_use_rs1_i(id_use_rs1_i), .id_use_rs2_i(id_use_rs2_i),
        .ex_memread_i(ex_memread_i), .ex_rd_i(ex_rd_i),
        .ex_branch_taken_i(ex_branch_taken_i), .imem_ready_i(imem_ready_i),
        .pc_we_o(pc_we1), .pc_sel_o(pc_sel1), .fd_we_o(fd_we1),
        .fd_flush_o(fd_flush1), .de_bubble_o(de_bubble1), .imem_abort_o(imem_abort1),
`ifdef HAZARD_PERF_CNT_EN
        .stall_cnt_o(stall_cnt1), .flush_cnt_o(flush_cnt1), .wait_cnt_o(wait_cnt1),
`endif
        .state_o(state1)
    );

    task automatic idle_inputs();
        id_rs1_i = 5'd0; id_rs2_i = 5'd0; ex_rd_i = 5'd0;
        id_use_rs1_i = 1'b0; id_use_rs2_i = 1'b0; ex_memread_i = 1'b0;
        ex_branch_taken_i = 1'b0; imem_ready_i = 1'b1;
    endtask

    task automatic drive_lu_rs1(input logic [4:0] r);
        ex_memread_i = 1'b1; ex_rd_i = r; id_rs1_i = r; id_use_rs1_i = 1'b1;
    endtask

    task automatic next_cycle();
        @(posedge clk_i); #1;
    endtask

    task automatic test_reset();
        @(negedge clk_i);
        total++;
        if (obs !== {ST_INIT, O_INIT}) begin
            bad++; $display("FAIL reset_hold: got %h expected %h", obs, {ST_INIT, O_INIT});
        end
        next_cycle();
        reset_i = 1'b1;
        @(negedge clk_i);
        total++;
        if (obs !== {ST_INIT, O_INIT}) begin
            bad++; $display("FAIL init_cycle: got %h expected %h", obs, {ST_INIT, O_INIT});
        end
        next_cycle();
    endtask

    task automatic test_normal();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            total++;
            if (obs !== {ST_RUN, O_NORM}) begin
                bad++; $display("FAIL normal[%0d]: got %h expected %h", i, obs, {ST_RUN, O_NORM});
            end
            next_cycle();
        end
    endtask

    task automatic test_load_use();
        logic [7:0] exp [4] = '{{ST_RUN, O_STALL}, {ST_LU, O_STALL}, {ST_LU, O_STALL}, {ST_RUN, O_NORM}};
        for (int i = 0; i < 4; i++) begin
            idle_inputs();
            if (i == 0) drive_lu_rs1(5'd5);
            @(negedge clk_i);
            total++;
            if (obs !== exp[i]) begin
                bad++; $display("FAIL load_use[%0d]: got %h expected %h", i, obs, exp[i]);
            end
            next_cycle();
        end
    endtask

    task automatic test_rd_zero();
        for (int i = 0; i < 2; i++) begin
            idle_inputs();
            drive_lu_rs1(5'd0);
            @(negedge clk_i);
            total++;
            if (obs !== {ST_RUN, O_NORM}) begin
                bad++; $display("FAIL rd_zero[%0d]: got %h expected %h", i, obs, {ST_RUN, O_NORM});
            end
            next_cycle();
        end
        idle_inputs();
    endtask

    task automatic test_lu_with_branch();
        logic [7:0] exp [2] = '{{ST_RUN, O_BR}, {ST_RUN, O_NORM}};
        for (int i = 0; i < 2; i++) begin
            idle_inputs();
            if (i == 0) begin
                drive_lu_rs1(5'd5);
                ex_branch_taken_i = 1'b1;
            end
            @(negedge clk_i);
            total++;
            if (obs !== exp[i]) begin
                bad++; $display("FAIL lu_branch[%0d]: got %h expected %h", i, obs, exp[i]);
            end
            next_cycle();
        end
    endtask

    task automatic test_imem_wait();
        logic [7:0] exp_a [6] = '{{ST_RUN, O_WAIT}, {ST_WAIT, O_WAIT}, {ST_WAIT, O_WAIT},
                                  {ST_WAIT, O_WAIT}, {ST_WAIT, O_NORM}, {ST_RUN, O_NORM}};
        logic [7:0] exp_b [4] = '{{ST_RUN, O_WAIT}, {ST_WAIT, O_WAIT}, {ST_WAIT, O_ABORT},
                                  {ST_RUN, O_NORM}};
        for (int i = 0; i < 6; i++) begin
            idle_inputs();
            imem_ready_i = (i >= 4);
            @(negedge clk_i);
            total++;
            if (obs !== exp_a[i]) begin
                bad++; $display("FAIL imem_wait[%0d]: got %h expected %h", i, obs, exp_a[i]);
            end
            next_cycle();
        end
        for (int i = 0; i < 4; i++) begin
            idle_inputs();
            imem_ready_i      = (i == 3);
            ex_branch_taken_i = (i == 2);
            @(negedge clk_i);
            total++;
            if (obs !== exp_b[i]) begin
                bad++; $display("FAIL imem_abort[%0d]: got %h expected %h", i, obs, exp_b[i]);
            end
            next_cycle();
        end
        idle_inputs();
    endtask

    task automatic test_perf_counters();
`ifdef HAZARD_PERF_CNT_EN
        @(negedge clk_i);
        total++;
        if (stall_cnt_o !== 32'd3) begin
            bad++; $display("FAIL stall_cnt: got %0d expected 3", stall_cnt_o);
        end
        total++;
        if (flush_cnt_o !== 32'd2) begin
            bad++; $display("FAIL flush_cnt: got %0d expected 2", flush_cnt_o);
        end
        total++;
        if (wait_cnt_o !== 32'd6) begin
            bad++; $display("FAIL wait_cnt: got %0d expected 6", wait_cnt_o);
        end
        next_cycle();
`endif
    endtask

    task automatic test_load_lat1();
        logic [7:0] exp1 [2] = '{{ST_RUN, O_STALL}, {ST_RUN, O_NORM}};
        for (int i = 0; i < 4; i++) begin
            idle_inputs();
            if (i == 0) drive_lu_rs1(5'd12);
            @(negedge clk_i);
            if (i < 2) begin
                total++;
                if (obs1 !== exp1[i]) begin
                    bad++; $display("FAIL lat1[%0d]: got %h expected %h", i, obs1, exp1[i]);
                end
            end
            next_cycle();
        end
        @(negedge clk_i);
        total++;
        if (obs !== {ST_RUN, O_NORM}) begin
            bad++; $display("FAIL lat1_main_back: got %h expected %h", obs, {ST_RUN, O_NORM});
        end
        next_cycle();
    endtask

    task automatic test_rs2_and_reentry();
        // Non-matching variants first: no stall.
        for (int i = 0; i < 2; i++) begin
            idle_inputs();
            if (i == 0) begin
                ex_memread_i = 1'b1; ex_rd_i = 5'd9; id_rs1_i = 5'd9; id_use_rs1_i = 1'b0;
            end else begin
                ex_memread_i = 1'b0; ex_rd_i = 5'd9; id_rs1_i = 5'd9; id_use_rs1_i = 1'b1;
            end
            @(negedge clk_i);
            total++;
            if (obs !== {ST_RUN, O_NORM}) begin
                bad++; $display("FAIL no_hazard[%0d]: got %h expected %h", i, obs, {ST_RUN, O_NORM});
            end
            next_cycle();
        end
        // rs2 hazard held for 4 cycles: stall completes, then restarts on re-entry.
        begin
            logic [7:0] exp [7] = '{{ST_RUN, O_STALL}, {ST_LU, O_STALL}, {ST_LU, O_STALL},
                                    {ST_RUN, O_STALL}, {ST_LU, O_STALL}, {ST_LU, O_STALL},
                                    {ST_RUN, O_NORM}};
            for (int i = 0; i < 7; i++) begin
                idle_inputs();
                if (i < 4) begin
                    ex_memread_i = 1'b1; ex_rd_i = 5'd7; id_rs2_i = 5'd7; id_use_rs2_i = 1'b1;
                end
                @(negedge clk_i);
                total++;
                if (obs !== exp[i]) begin
                    bad++; $display("FAIL rs2_reentry[%0d]: got %h expected %h", i, obs, exp[i]);
                end
                next_cycle();
            end
        end
    endtask

    task automatic test_branch_in_stall();
        logic [7:0] exp [3] = '{{ST_RUN, O_STALL}, {ST_LU, O_BR}, {ST_RUN, O_NORM}};
        for (int i = 0; i < 3; i++) begin
            idle_inputs();
            if (i == 0) drive_lu_rs1(5'd3);
            if (i == 1) ex_branch_taken_i = 1'b1;
            @(negedge clk_i);
            total++;
            if (obs !== exp[i]) begin
                bad++; $display("FAIL branch_in_stall[%0d]: got %h expected %h", i, obs, exp[i]);
            end
            next_cycle();
        end
    endtask

    task automatic test_reset_mid_stall();
        idle_inputs();
        drive_lu_rs1(5'd4);
        next_cycle();
        idle_inputs();
        @(negedge clk_i);
        total++;
        if (state_o !== ST_LU) begin
            bad++; $display("FAIL pre_reset_state: got %0d expected %0d", state_o, ST_LU);
        end
        #2 reset_i = 1'b0;
        #1;
        total++;
        if (obs !== {ST_INIT, O_INIT}) begin
            bad++; $display("FAIL async_reset: got %h expected %h", obs, {ST_INIT, O_INIT});
        end
`ifdef HAZARD_PERF_CNT_EN
        total++;
        if ({stall_cnt_o, flush_cnt_o, wait_cnt_o} !== 96'd0) begin
            bad++; $display("FAIL perf_reset: got %0d %0d %0d expected 0 0 0",
                            stall_cnt_o, flush_cnt_o, wait_cnt_o);
        end
`endif
        next_cycle();
        reset_i = 1'b1;
        @(negedge clk_i);
        total++;
        if (obs !== {ST_INIT, O_INIT}) begin
            bad++; $display("FAIL post_reset_init: got %h expected %h", obs, {ST_INIT, O_INIT});
        end
        next_cycle();
        @(negedge clk_i);
        total++;
        if (obs !== {ST_RUN, O_NORM}) begin
            bad++; $display("FAIL post_reset_run: got %h expected %h", obs, {ST_RUN, O_NORM});
        end
    endtask

    initial begin
        reset_i = 1'b0;
        idle_inputs();
        test_reset();
        test_normal();
        test_load_use();
        test_rd_zero();
        test_lu_with_branch();
        test_imem_wait();
        test_perf_counters();
        test_load_lat1();
        test_rs2_and_reentry();
        test_branch_in_stall();
        test_reset_mid_stall();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
